// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Command codes, FSM state encoding and byte-counter width
//                shared by the I2C register-burst sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int c_cnt_w = 3;

    // Command codes understood by the byte-level I2C master core
    localparam logic [2:0] c_cmd_start     = 3'd0;
    localparam logic [2:0] c_cmd_write     = 3'd1;
    localparam logic [2:0] c_cmd_read_ack  = 3'd2;
    localparam logic [2:0] c_cmd_read_nack = 3'd3;
    localparam logic [2:0] c_cmd_stop      = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_ADDR   = 4'd2,
        ST_PTR    = 4'd3,
        ST_DATA   = 4'd4,
        ST_STOP   = 4'd5,
        ST_FINISH = 4'd6,
        ST_RSTART = 4'd7,
        ST_RADDR  = 4'd8,
        ST_RDATA  = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_reg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_seq
//  Description : Sequences START / address / pointer / data bytes / STOP
//                commands into a byte-level I2C master core. Defining
//                I2C_READBACK_EN adds a repeated-START readback-verify pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int         NUM_REGS = 4,
    parameter logic [7:0] BASE_REG = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [6:0]            slv_addr,
    input  logic [8*NUM_REGS-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  nack_err,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [2:0]            cmd,
    output logic [7:0]            tx_data,
    input  logic                  rsp_valid,
    input  logic                  rx_ack,
    input  logic [7:0]            rx_data
`ifdef I2C_READBACK_EN
    ,
    output logic                  mismatch
`endif
);

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_REGS - 1);

    state_t                r_state;
    logic                  r_wait;
    logic                  r_err;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [6:0]            r_addr;
    logic [8*NUM_REGS-1:0] r_data;

    logic [c_cnt_w-1:0]    w_cnt_inc;
    logic [63:0]           w_pad;
    logic [7:0]            w_byte_nxt;

    // Zero-padded to 64 bits so the 3-bit counter indexes bytes without width games
    assign w_cnt_inc  = r_cnt + c_cnt_w'(1);
    assign w_pad      = 64'(r_data);
    assign w_byte_nxt = w_pad[{w_cnt_inc, 3'b000} +: 8];

`ifdef I2C_READBACK_EN
    logic [7:0] w_byte_cur;
    assign w_byte_cur = w_pad[{r_cnt, 3'b000} +: 8];
`else
    logic w_unused_rx;
    assign w_unused_rx = ^rx_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wait    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack_err  <= 1'b0;
            cmd_valid <= 1'b0;
            cmd       <= c_cmd_start;
            tx_data   <= 8'h00;
`ifdef I2C_READBACK_EN
            mismatch  <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            nack_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr    <= slv_addr;
                        r_data    <= wr_data;
                        r_err     <= 1'b0;
                        r_cnt     <= '0;
                        r_wait    <= 1'b0;
                        busy      <= 1'b1;
                        cmd_valid <= 1'b1;
                        cmd       <= c_cmd_start;
                        tx_data   <= 8'h00;
                        r_state   <= ST_START;
`ifdef I2C_READBACK_EN
                        mismatch  <= 1'b0;
`endif
                    end
                end
                ST_FINISH: begin
                    busy     <= 1'b0;
                    done     <= ~r_err;
                    nack_err <= r_err;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    if (!r_wait) begin
                        if (cmd_ready) begin
                            cmd_valid <= 1'b0;
                            r_wait    <= 1'b1;
                        end
                    end else if (rsp_valid) begin
                        // Next command is registered here; STOP response overrides below
                        r_wait    <= 1'b0;
                        cmd_valid <= 1'b1;
                        tx_data   <= 8'h00;
                        case (r_state)
                            ST_START: begin
                                cmd     <= c_cmd_write;
                                tx_data <= {r_addr, 1'b0};
                                r_state <= ST_ADDR;
                            end
                            ST_ADDR: begin
                                if (rx_ack) begin
                                    r_err   <= 1'b1;
                                    cmd     <= c_cmd_stop;
                                    r_state <= ST_STOP;
                                end else begin
                                    cmd     <= c_cmd_write;
                                    tx_data <= BASE_REG;
                                    r_state <= ST_PTR;
                                end
                            end
                            ST_PTR: begin
                                if (rx_ack) begin
                                    r_err   <= 1'b1;
                                    cmd     <= c_cmd_stop;
                                    r_state <= ST_STOP;
                                end else begin
                                    r_cnt   <= '0;
                                    cmd     <= c_cmd_write;
                                    tx_data <= w_pad[7:0];
                                    r_state <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                if (rx_ack) begin
                                    r_err   <= 1'b1;
                                    cmd     <= c_cmd_stop;
                                    r_state <= ST_STOP;
                                end else if (r_cnt == c_last) begin
`ifdef I2C_READBACK_EN
                                    r_cnt   <= '0;
                                    cmd     <= c_cmd_start;
                                    r_state <= ST_RSTART;
`else
                                    cmd     <= c_cmd_stop;
                                    r_state <= ST_STOP;
`endif
                                end else begin
                                    r_cnt   <= w_cnt_inc;
                                    cmd     <= c_cmd_write;
                                    tx_data <= w_byte_nxt;
                                end
                            end
`ifdef I2C_READBACK_EN
                            ST_RSTART: begin
                                cmd     <= c_cmd_write;
                                tx_data <= {r_addr, 1'b1};
                                r_state <= ST_RADDR;
                            end
                            ST_RADDR: begin
                                if (rx_ack) begin
                                    r_err   <= 1'b1;
                                    cmd     <= c_cmd_stop;
                                    r_state <= ST_STOP;
                                end else begin
                                    cmd     <= (c_last == '0) ? c_cmd_read_nack : c_cmd_read_ack;
                                    r_state <= ST_RDATA;
                                end
                            end
                            ST_RDATA: begin
                                if (rx_data != w_byte_cur) begin
                                    mismatch <= 1'b1;
                                end
                                if (r_cnt == c_last) begin
                                    cmd     <= c_cmd_stop;
                                    r_state <= ST_STOP;
                                end else begin
                                    r_cnt   <= w_cnt_inc;
                                    cmd     <= (w_cnt_inc == c_last) ? c_cmd_read_nack : c_cmd_read_ack;
                                end
                            end
`endif
                            ST_STOP: begin
                                cmd_valid <= 1'b0;
                                r_state   <= ST_FINISH;
                            end
                            default: begin
                                cmd_valid <= 1'b0;
                                r_state   <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_reg_seq
//  Description : Directed self-checking bench for i2c_reg_seq with a
//                behavioural byte-level master core responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_seq;

    localparam logic [2:0] c_start = 3'd0;
    localparam logic [2:0] c_write = 3'd1;
    localparam logic [2:0] c_rack  = 3'd2;
    localparam logic [2:0] c_rnack = 3'd3;
    localparam logic [2:0] c_stop  = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  slv_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy, done, nack_err, cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd;
    logic [7:0]  tx_data;
    logic        rsp_valid = 1'b0;
    logic        rx_ack = 1'b0;
    logic [7:0]  rx_data = '0;
`ifdef I2C_READBACK_EN
    logic        mismatch;
`endif

    int checks = 0;
    int failures = 0;

    // Responder / model state
    int          stall = 0, vcnt = 0, pend = 0, nack_at = -1, rd_idx = 0, unstable = 0;
    bit          spurious = 0;
    logic        pend_ack;
    logic [7:0]  pend_dat, hold_dat;
    logic [2:0]  hold_cmd;
    logic [7:0]  rd_bytes [4];
    logic [2:0]  log_cmd[$], exp_cmd[$];
    logic [7:0]  log_dat[$], exp_dat[$];
    bit          exp_nack;
    int          done_cnt = 0, nack_cnt = 0;

    i2c_reg_seq #(.NUM_REGS(4), .BASE_REG(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .slv_addr  (slv_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .nack_err  (nack_err),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .tx_data   (tx_data),
        .rsp_valid (rsp_valid),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data)
`ifdef I2C_READBACK_EN
        ,
        .mismatch  (mismatch)
`endif
    );

    always #5 clk = ~clk;

    // Master-core model: raises ready after 'stall' cycles, logs the accepted
    // command and answers two cycles after the handshake edge.
    always @(negedge clk) begin
        if (reset) begin
            rsp_valid = 1'b0; cmd_ready = 1'b0; vcnt = 0; pend = 0;
        end else begin
            rsp_valid = 1'b0; rx_ack = 1'b0; cmd_ready = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin rsp_valid = 1'b1; rx_ack = pend_ack; rx_data = pend_dat; end
            end
            if (cmd_valid) begin
                if (vcnt == 0) begin hold_cmd = cmd; hold_dat = tx_data; end
                else if (cmd !== hold_cmd || tx_data !== hold_dat) unstable++;
                if (spurious && vcnt == 1) begin rsp_valid = 1'b1; rx_ack = 1'b1; rx_data = 8'hFF; end
                if (vcnt >= stall) begin
                    cmd_ready = 1'b1;
                    if (cmd == c_start) rd_idx = 0;
                    pend_ack = (cmd == c_write) && (log_cmd.size() == nack_at);
                    pend_dat = 8'h00;
                    if (cmd == c_rack || cmd == c_rnack) begin pend_dat = rd_bytes[rd_idx[1:0]]; rd_idx++; end
                    log_cmd.push_back(cmd); log_dat.push_back(tx_data);
                    pend = 2; vcnt = 0;
                end else vcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (nack_err) nack_cnt++;
    end

    function automatic void build_exp(input logic [6:0] a, input logic [31:0] d);
        logic [7:0] w [6];
        exp_cmd.delete(); exp_dat.delete(); exp_nack = 0;
        w = '{{a, 1'b0}, 8'h00, d[7:0], d[15:8], d[23:16], d[31:24]};
        exp_cmd.push_back(c_start); exp_dat.push_back(8'h00);
        for (int i = 0; i < 6; i++) begin
            exp_cmd.push_back(c_write); exp_dat.push_back(w[i]);
            if (exp_cmd.size() - 1 == nack_at) begin exp_nack = 1; break; end
        end
`ifdef I2C_READBACK_EN
        if (!exp_nack) begin
            exp_cmd.push_back(c_start); exp_dat.push_back(8'h00);
            exp_cmd.push_back(c_write); exp_dat.push_back({a, 1'b1});
            if (exp_cmd.size() - 1 == nack_at) exp_nack = 1;
            else for (int i = 0; i < 4; i++) begin
                exp_cmd.push_back(i == 3 ? c_rnack : c_rack); exp_dat.push_back(8'h00);
            end
        end
`endif
        exp_cmd.push_back(c_stop); exp_dat.push_back(8'h00);
    endfunction

    function automatic string fmt(input logic [2:0] c[$], input logic [7:0] d[$]);
        string s = "";
        foreach (c[i]) begin
            case (c[i])
                c_start: s = {s, "S "};
                c_write: s = {s, $sformatf("W%02h ", d[i])};
                c_rack:  s = {s, "RA "};
                c_rnack: s = {s, "RN "};
                c_stop:  s = {s, "P "};
                default: s = {s, "? "};
            endcase
        end
        return s;
    endfunction

    task automatic kick(input logic [6:0] a, input logic [31:0] d, output logic busy_seen);
        log_cmd.delete(); log_dat.delete(); done_cnt = 0; nack_cnt = 0; unstable = 0;
        @(negedge clk); slv_addr = a; wr_data = d; start = 1'b1;
        @(negedge clk); start = 1'b0; busy_seen = busy;
    endtask

    task automatic wait_end(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done || nack_err) begin ok = 1; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (nack_err !== 1'b0)  begin failures++; $display("FAIL rst_nack got=%b exp=0", nack_err); end
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid got=%b exp=0", cmd_valid); end
        checks++; if (cmd !== 3'd0)       begin failures++; $display("FAIL rst_cmd got=%0d exp=0", cmd); end
        checks++; if (tx_data !== 8'h00)  begin failures++; $display("FAIL rst_tx_data got=%02h exp=00", tx_data); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic b; bit ok;
        nack_at = -1; stall = 0; spurious = 0;
        build_exp(7'h42, 32'hDDCCBBAA);
        kick(7'h42, 32'hDDCCBBAA, b);
        wait_end(ok);
        checks++; if (!ok)        begin failures++; $display("FAIL basic_timeout got=none exp=done"); end
        checks++; if (b !== 1'b1) begin failures++; $display("FAIL basic_busy_on got=%b exp=1", b); end
        checks++; if (fmt(log_cmd, log_dat) != fmt(exp_cmd, exp_dat))
            begin failures++; $display("FAIL basic_seq got=[%s] exp=[%s]", fmt(log_cmd, log_dat), fmt(exp_cmd, exp_dat)); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
        checks++; if (nack_cnt !== 0) begin failures++; $display("FAIL basic_nack got=%0d exp=0", nack_cnt); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL basic_busy_off got=%b exp=0", busy); end
    endtask

    task automatic test_nack(input int at, input string nm);
        logic b; bit ok;
        nack_at = at; stall = 0; spurious = 0;
        build_exp(7'h42, 32'hDDCCBBAA);
        kick(7'h42, 32'hDDCCBBAA, b);
        wait_end(ok);
        checks++; if (!ok) begin failures++; $display("FAIL %s_timeout got=none exp=nack_err", nm); end
        checks++; if (fmt(log_cmd, log_dat) != fmt(exp_cmd, exp_dat))
            begin failures++; $display("FAIL %s_seq got=[%s] exp=[%s]", nm, fmt(log_cmd, log_dat), fmt(exp_cmd, exp_dat)); end
        checks++; if (nack_cnt !== 1) begin failures++; $display("FAIL %s_nack got=%0d exp=1", nm, nack_cnt); end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL %s_done got=%0d exp=0", nm, done_cnt); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL %s_busy_off got=%b exp=0", nm, busy); end
        nack_at = -1;
    endtask

    task automatic test_stall;
        logic b; bit ok;
        nack_at = -1; stall = 5; spurious = 1;
        build_exp(7'h42, 32'hDDCCBBAA);
        kick(7'h42, 32'hDDCCBBAA, b);
        wait_end(ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=none exp=done"); end
        checks++; if (fmt(log_cmd, log_dat) != fmt(exp_cmd, exp_dat))
            begin failures++; $display("FAIL stall_seq got=[%s] exp=[%s]", fmt(log_cmd, log_dat), fmt(exp_cmd, exp_dat)); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
        stall = 0; spurious = 0;
    endtask

    task automatic test_back_to_back_start;
        logic b; bit ok;
        nack_at = -1; stall = 0;
        build_exp(7'h42, 32'hDDCCBBAA);
        kick(7'h42, 32'hDDCCBBAA, b);
        for (int i = 0; i < 200 && log_cmd.size() < 3; i++) @(negedge clk);
        slv_addr = 7'h10; wr_data = 32'h55667788; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_end(ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL restart_timeout got=none exp=done"); end
        checks++; if (fmt(log_cmd, log_dat) != fmt(exp_cmd, exp_dat))
            begin failures++; $display("FAIL restart_seq got=[%s] exp=[%s]", fmt(log_cmd, log_dat), fmt(exp_cmd, exp_dat)); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid;
        logic b; bit ok;
        nack_at = -1; stall = 0;
        kick(7'h42, 32'hDDCCBBAA, b);
        for (int i = 0; i < 200 && log_cmd.size() < 6; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL midrst_cmd_valid got=%b exp=0", cmd_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        @(negedge clk); reset = 1'b0;
        build_exp(7'h2A, 32'h44332211);
        kick(7'h2A, 32'h44332211, b);
        wait_end(ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout got=none exp=done"); end
        checks++; if (fmt(log_cmd, log_dat) != fmt(exp_cmd, exp_dat))
            begin failures++; $display("FAIL midrst_seq got=[%s] exp=[%s]", fmt(log_cmd, log_dat), fmt(exp_cmd, exp_dat)); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL midrst_done got=%0d exp=1", done_cnt); end
    endtask

`ifdef I2C_READBACK_EN
    task automatic test_readback;
        logic b; bit ok;
        nack_at = -1; stall = 0;
        rd_bytes = '{8'hAA, 8'hBB, 8'hCE, 8'hDD};
        build_exp(7'h42, 32'hDDCCBBAA);
        kick(7'h42, 32'hDDCCBBAA, b);
        wait_end(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rb_bad_timeout got=none exp=done"); end
        checks++; if (fmt(log_cmd, log_dat) != fmt(exp_cmd, exp_dat))
            begin failures++; $display("FAIL rb_bad_seq got=[%s] exp=[%s]", fmt(log_cmd, log_dat), fmt(exp_cmd, exp_dat)); end
        checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL rb_bad_mismatch got=%b exp=1", mismatch); end
        rd_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        kick(7'h42, 32'hDDCCBBAA, b);
        wait_end(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rb_good_timeout got=none exp=done"); end
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL rb_good_mismatch got=%b exp=0", mismatch); end
        checks++; if (done_cnt !== 1)    begin failures++; $display("FAIL rb_good_done got=%0d exp=1", done_cnt); end
    endtask
`endif

    initial begin
        rd_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        test_reset();
        test_basic();
        test_nack(1, "addr_nack");
        test_nack(4, "data_nack");
        test_stall();
        test_back_to_back_start();
        test_reset_mid();
`ifdef I2C_READBACK_EN
        test_readback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 Parameter NUM_REGS, default 4: register bytes written per transaction (1..8).
REQ-002 Parameter BASE_REG, default 8'h00: register pointer byte sent after the address byte.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a register-burst transaction.
REQ-006 slv_addr  input  7  7-bit I2C target address.
REQ-007 wr_data  input  8*NUM_REGS  bytes to write; byte k is bits [8k+7:8k] and goes to register BASE_REG+k.
REQ-008 busy  output  1  high from the accepted start until done or err.
REQ-009 done  output  1  one-cycle pulse when a transaction completes without error.
REQ-010 nack_err  output  1  one-cycle pulse when a transaction aborts because the target NACKed.
REQ-011 cmd_valid  output  1  command offered to the byte-level I2C master core.
REQ-012 cmd_ready  input  1  master core accepts the command in a cycle where cmd_valid and cmd_ready are both high.
REQ-013 cmd  output  3  command code: START=0, WRITE=1, READ_ACK=2, READ_NACK=3, STOP=4.
REQ-014 tx_data  output  8  byte for a WRITE command.
REQ-015 rsp_valid  input  1  one-cycle pulse when the master core finishes the accepted command.
REQ-016 rx_ack  input  1  ACK bit sampled after a WRITE (0=ACK, 1=NACK); valid with rsp_valid.
REQ-017 rx_data  input  8  byte returned by a READ command; valid with rsp_valid.

Function
REQ-018 States: IDLE, START, ADDR, PTR, DATA, STOP, FINISH; readback adds RSTART, RADDR, RDATA (REQ-032).
REQ-019 In IDLE, start latches slv_addr and wr_data into internal registers, sets busy next cycle and moves to START.
REQ-020 A start while busy is high is ignored; the latched inputs do not change during a transaction.
REQ-021 Each state issues exactly one command, holds cmd_valid, cmd and tx_data stable until the handshake completes, then drops cmd_valid and waits for rsp_valid.
REQ-022 Command order: START; WRITE {slv_addr,1'b0}; WRITE BASE_REG; WRITE byte 0..NUM_REGS-1 in ascending order; STOP.
REQ-023 A 3-bit byte counter selects the DATA byte; the controller leaves DATA after byte NUM_REGS-1 is acknowledged.
REQ-024 rx_ack=1 on any WRITE response sets an error flag and moves to STOP; after the STOP response it pulses nack_err, not done.
REQ-025 After the STOP response, FINISH pulses done or nack_err for one cycle, clears busy in the same cycle and returns to IDLE.
REQ-026 rsp_valid outside a wait-for-response phase is ignored.
REQ-027 Minimum transaction time is fixed by the core's response latency; the sequencer adds at most one idle cycle between a response and the next cmd_valid.

Reset
REQ-028 Reset forces IDLE and clears the byte counter and error flag in the next cycle, including mid-transaction.
REQ-029 Reset values: busy=0, done=0, nack_err=0, cmd_valid=0, cmd=0, tx_data=0, mismatch=0.
REQ-030 Reset does not issue STOP; recovering the bus is the master core's job.

Configuration
REQ-031 Macro I2C_READBACK_EN compiles in a readback-verify pass; without it, ports and behaviour are exactly as in REQ-018 to REQ-027.
REQ-032 With the macro: after DATA, issue START (repeated), WRITE {slv_addr,1'b1}, READ_ACK for bytes 0..NUM_REGS-2, READ_NACK for the last byte, then STOP.
REQ-033 Each read byte is compared with the latched byte; any difference sets the output port mismatch (1 bit), valid from the done pulse until the next accepted start.
REQ-034 The readback pass is skipped if any write byte was NACKed.

Structure
REQ-035 Package i2c_pkg holds the command-code constants, the state enumeration and the byte-counter width.
REQ-036 The module is one flat FSM plus datapath with no sub-module; it instantiates beside the byte-level master core, and no sub-module is required.

Verification
REQ-037 Basic burst: slv_addr=7'h42, NUM_REGS=4, wr_data=32'hDDCCBBAA, all ACKs -> bytes 84,00,AA,BB,CC,DD between START and STOP; one done pulse; busy low afterwards.
REQ-038 NACK on the address byte -> next command is STOP, no data bytes issued, one nack_err pulse, no done pulse.
REQ-039 cmd_ready held low for 5 cycles on each command -> cmd, cmd_valid and tx_data stay stable, the sequence is unchanged, and there are no duplicate issues.
REQ-040 start pulsed again mid-burst with slv_addr=7'h10 -> ignored; the whole transaction still uses address 7'h42.
REQ-041 reset asserted during DATA byte 2 -> cmd_valid and busy are 0 the next cycle; a fresh start then runs a complete correct burst.
REQ-042 With I2C_READBACK_EN, readback returns AA,BB,0xCE,DD -> READ_NACK on the 4th byte and mismatch=1 at done; with correct data, mismatch=0.
